// File: rtl/key_expander.sv
// Kuznyechik (GOST R 34.12-2015) key schedule: 256-bit master key -> ten 128-bit round keys.
// Define CONST_ROM_EN to read C_1..C_32 from a constant ROM instead of generating them on the shared L unit.

package key_expander_pkg;

    // Linear-map coefficients; byte k here multiplies state byte k (byte 15 = most significant).
    localparam logic [127:0] L_COEF = 128'h94208510C2C001FB01C0C21085209401;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            acc = b[k] ? (acc ^ x) : acc;
            x   = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

    function automatic logic [127:0] r_step(input logic [127:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int k = 0; k < 16; k++) begin
            acc = acc ^ gf_mul(v[8*k +: 8], L_COEF[8*k +: 8]);
        end
        return {acc, v[127:8]};
    endfunction

    function automatic logic [127:0] l_full(input logic [127:0] v);
        logic [127:0] acc;
        acc = v;
        for (int k = 0; k < 16; k++) begin
            acc = r_step(acc);
        end
        return acc;
    endfunction

endpackage

module S_convertion (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam logic [2047:0] PI = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    // Entry x sits at bit 2047-8x, i.e. {~x, 3'b111}.
    assign data_out = PI[{~data_in, 3'b111} -: 8];
endmodule

module L_convertion (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         finish_convertion
);
    import key_expander_pkg::*;

    logic [127:0] data_r;
    logic [3:0]   cnt_r;
    logic         busy_r;
    logic         done_r;

    // Load on the first enabled cycle, then 16 R steps; dropping enable rearms the unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= 128'd0;
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (!enable) begin
            cnt_r  <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (busy_r) begin
            data_r <= r_step(data_r);
            cnt_r  <= cnt_r + 4'd1;
            if (cnt_r == 4'd15) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end
        end else if (!done_r) begin
            data_r <= data_in;
            cnt_r  <= 4'd0;
            busy_r <= 1'b1;
        end
    end

    assign data_out          = data_r;
    assign finish_convertion = done_r;
endmodule

module key_expander
    import key_expander_pkg::*;
#(
    parameter int ITER_PER_PAIR = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [255:0] master_key,
    output logic [127:0] key_1,
    output logic [127:0] key_2,
    output logic [127:0] key_3,
    output logic [127:0] key_4,
    output logic [127:0] key_5,
    output logic [127:0] key_6,
    output logic [127:0] key_7,
    output logic [127:0] key_8,
    output logic [127:0] key_9,
    output logic [127:0] key_10,
    output logic         finish
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CGEN, S_XS, S_LRUN, S_FEIST, S_STORE, S_DONE
    } state_t;

    state_t       state_r;
    state_t       state_next_s;
    logic [127:0] a1_r;
    logic [127:0] a0_r;
    logic [127:0] t_r;
    logic [5:0]   i_r;
    logic         l_en_r;
    logic         finish_r;
    logic [127:0] keys_r [1:10];

    logic [127:0] c_s;
    logic [127:0] l_in_s;
    logic [127:0] l_out_s;
    logic         l_finish_s;
    logic [127:0] sx_in_s;
    logic [127:0] sx_out_s;
    logic [5:0]   rounds_done_s;
    logic         pair_store_s;
    logic         last_round_s;
    logic [2:0]   pair_idx_s;
    logic [3:0]   key_odd_idx_s;
    logic [3:0]   key_even_idx_s;

`ifdef CONST_ROM_EN
    function automatic logic [8191:0] build_c_table();
        logic [8191:0] tbl;
        tbl = 8192'd0;
        for (int k = 1; k <= 32; k++) begin
            tbl[128*k +: 128] = l_full({120'd0, 8'(k)});
        end
        return tbl;
    endfunction

    localparam logic [8191:0] C_TABLE = build_c_table();

    assign c_s    = C_TABLE[{i_r, 7'd0} +: 128];
    assign l_in_s = t_r;
`else
    logic [127:0] c_r;

    // Round constant C_i latched when the shared L unit finishes on Vec128(i).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_r <= 128'd0;
        end else if ((state_r == S_CGEN) && l_finish_s) begin
            c_r <= l_out_s;
        end
    end

    assign c_s    = c_r;
    assign l_in_s = (state_r == S_CGEN) ? {122'd0, i_r} : t_r;
`endif

    assign rounds_done_s  = i_r - 6'd1;
    assign pair_store_s   = (rounds_done_s % 6'(ITER_PER_PAIR)) == 6'd0;
    assign pair_idx_s     = 3'(rounds_done_s / 6'(ITER_PER_PAIR));
    assign last_round_s   = rounds_done_s == 6'(4 * ITER_PER_PAIR);
    assign key_odd_idx_s  = {pair_idx_s, 1'b1};
    assign key_even_idx_s = {pair_idx_s + 3'd1, 1'b0};
    assign sx_in_s        = a1_r ^ c_s;

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        S_convertion u_s (
            .data_in  (sx_in_s[8*g +: 8]),
            .data_out (sx_out_s[8*g +: 8])
        );
    end

    L_convertion u_l (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (l_en_r),
        .data_in           (l_in_s),
        .data_out          (l_out_s),
        .finish_convertion (l_finish_s)
    );

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  state_next_s = enable ? S_LOAD : S_IDLE;
`ifdef CONST_ROM_EN
            S_LOAD:  state_next_s = S_XS;
            S_CGEN:  state_next_s = S_XS;
`else
            S_LOAD:  state_next_s = S_CGEN;
            S_CGEN:  state_next_s = l_finish_s ? S_XS : S_CGEN;
`endif
            S_XS:    state_next_s = S_LRUN;
            S_LRUN:  state_next_s = l_finish_s ? S_FEIST : S_LRUN;
            S_FEIST: state_next_s = S_STORE;
            S_STORE: begin
                if (last_round_s) begin
                    state_next_s = S_DONE;
                end else begin
`ifdef CONST_ROM_EN
                    state_next_s = S_XS;
`else
                    state_next_s = S_CGEN;
`endif
                end
            end
            S_DONE:  state_next_s = enable ? S_DONE : S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register, Feistel datapath and round-key storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            a1_r     <= 128'd0;
            a0_r     <= 128'd0;
            t_r      <= 128'd0;
            i_r      <= 6'd0;
            l_en_r   <= 1'b0;
            finish_r <= 1'b0;
            for (int k = 1; k <= 10; k++) begin
                keys_r[k] <= 128'd0;
            end
        end else begin
            state_r <= state_next_s;
            // Enable follows the conversion states so it always drops between two conversions.
            l_en_r  <= (state_next_s == S_LRUN) || (state_next_s == S_CGEN);
            case (state_r)
                S_LOAD: begin
                    a1_r      <= master_key[255:128];
                    a0_r      <= master_key[127:0];
                    keys_r[1] <= master_key[255:128];
                    keys_r[2] <= master_key[127:0];
                    for (int k = 3; k <= 10; k++) begin
                        keys_r[k] <= 128'd0;
                    end
                    i_r      <= 6'd1;
                    finish_r <= 1'b0;
                end
                S_XS: t_r <= sx_out_s;
                S_FEIST: begin
                    a1_r <= l_out_s ^ a0_r;
                    a0_r <= a1_r;
                    i_r  <= i_r + 6'd1;
                end
                S_STORE: begin
                    if (pair_store_s) begin
                        keys_r[key_odd_idx_s]  <= a1_r;
                        keys_r[key_even_idx_s] <= a0_r;
                    end
                    if (last_round_s) begin
                        finish_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        finish_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_1  = keys_r[1];
    assign key_2  = keys_r[2];
    assign key_3  = keys_r[3];
    assign key_4  = keys_r[4];
    assign key_5  = keys_r[5];
    assign key_6  = keys_r[6];
    assign key_7  = keys_r[7];
    assign key_8  = keys_r[8];
    assign key_9  = keys_r[9];
    assign key_10 = keys_r[10];
    assign finish = finish_r;
endmodule

// File: tb/tb_key_expander.sv
// Scoreboard bench for key_expander: a byte-level GOST key-schedule model feeds an expected queue
// that a monitor drains each time finish rises.
module tb_key_expander;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [255:0] master_key;
    logic [127:0] key_1, key_2, key_3, key_4, key_5, key_6, key_7, key_8, key_9, key_10;
    logic         finish;

    int pass_cnt  = 0;
    int check_cnt = 0;
    logic [1279:0] exp_q [$];
    logic          fin_prev = 1'b0;

    localparam logic [255:0] T1_KEY =
        256'h8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef;

    int lcoef [16] = '{1, 148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148};
    logic [127:0] sbox_rows [16] = '{
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    always #5 clk = ~clk;

    key_expander dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .master_key(master_key),
        .key_1(key_1), .key_2(key_2), .key_3(key_3), .key_4(key_4), .key_5(key_5),
        .key_6(key_6), .key_7(key_7), .key_8(key_8), .key_9(key_9), .key_10(key_10),
        .finish(finish)
    );

    // GF(2^8) multiply: carry-less product, then reduce by x^8+x^7+x^6+x+1.
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'd0;
        for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (15'(a) << k);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'(9'h1C3) << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [127:0] row;
        row = sbox_rows[x[7:4]];
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    function automatic logic [127:0] m_lin(input logic [127:0] v);
        logic [7:0]   b [16];
        logic [7:0]   nb;
        logic [127:0] r;
        for (int j = 0; j < 16; j++) b[j] = v[8*j +: 8];
        for (int n = 0; n < 16; n++) begin
            nb = 8'h00;
            for (int j = 0; j < 16; j++) nb = nb ^ m_mul(b[j], 8'(lcoef[j]));
            for (int j = 0; j < 15; j++) b[j] = b[j + 1];
            b[15] = nb;
        end
        for (int j = 0; j < 16; j++) r[8*j +: 8] = b[j];
        return r;
    endfunction

    // Key n of the result sits at bits [128*(n-1) +: 128].
    function automatic logic [1279:0] m_expand(input logic [255:0] mk);
        logic [1279:0] e;
        logic [127:0]  a1, a0, x, s, y;
        e  = 1280'd0;
        a1 = mk[255:128];
        a0 = mk[127:0];
        e[0 +: 128]   = a1;
        e[128 +: 128] = a0;
        for (int i = 1; i <= 32; i++) begin
            x = a1 ^ m_lin(128'(i));
            for (int j = 0; j < 16; j++) s[8*j +: 8] = m_sbox(x[8*j +: 8]);
            y  = m_lin(s) ^ a0;
            a0 = a1;
            a1 = y;
            if (i % 8 == 0) begin
                e[128*(2*(i/8)) +: 128]     = a1;
                e[128*(2*(i/8) + 1) +: 128] = a0;
            end
        end
        return e;
    endfunction

    function automatic logic [1279:0] t1_expected();
        logic [1279:0] e;
        e = m_expand(T1_KEY);
        e[128*2 +: 128] = 128'hdb31485315694343228d6aef8cc78c44;
        e[128*3 +: 128] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
        e[128*8 +: 128] = 128'hbb44e25378c73123a5f32f73cdb6e517;
        e[128*9 +: 128] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
        return e;
    endfunction

    function automatic logic [127:0] get_key(input int n);
        case (n)
            1: return key_1;   2: return key_2;   3: return key_3;   4: return key_4;
            5: return key_5;   6: return key_6;   7: return key_7;   8: return key_8;
            9: return key_9;   default: return key_10;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: on each rising finish pop the oldest expectation and compare all ten keys.
    always @(negedge clk) begin
        if (finish && !fin_prev) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("FAIL unexpected_finish: got finish=1 with no request outstanding, expected 0");
            end else begin
                logic [1279:0] e;
                e = exp_q.pop_front();
                for (int n = 1; n <= 10; n++) chk($sformatf("key_%0d", n), get_key(n), e[128*(n-1) +: 128]);
            end
        end
        fin_prev <= finish;
    end

    task automatic wait_finish(input string tag, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (finish) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check_cnt++;
            $display("FAIL %s_timeout: finish=%b, expected 1 within 3000 cycles", tag, finish);
        end
    endtask

    task automatic run_req(input string tag, input logic [255:0] mk, input logic [1279:0] e,
                           input bit drop_early);
        bit ok;
        @(negedge clk);
        master_key = mk;
        enable     = 1'b1;
        exp_q.push_back(e);
        if (drop_early) begin
            repeat (3) @(negedge clk);
            enable = 1'b0;
        end
        wait_finish(tag, ok);
        if (ok && drop_early) begin
            @(negedge clk);
            chk({tag, "_finish_pulse"}, 128'(finish), 128'd0);
        end else if (ok) begin
            repeat (30) @(negedge clk);
            chk({tag, "_hold_finish"}, 128'(finish), 128'd1);
            chk({tag, "_hold_key10"}, key_10, e[128*9 +: 128]);
            enable = 1'b0;
            @(negedge clk);
            chk({tag, "_drop_finish"}, 128'(finish), 128'd0);
            chk({tag, "_idle_key3"}, key_3, e[128*2 +: 128]);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit            ok;
        logic [255:0]  mk;
        rst_n      = 1'b0;
        enable     = 1'b0;
        master_key = 256'd0;
        repeat (3) @(negedge clk);
        chk("reset_finish", 128'(finish), 128'd0);
        chk("reset_key1", key_1, 128'd0);
        chk("reset_key10", key_10, 128'd0);
        rst_n = 1'b1;

        run_req("t1", T1_KEY, t1_expected(), 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < 8; w++) mk[32*w +: 32] = $urandom;
            run_req($sformatf("rand%0d", r), mk, m_expand(mk), r[0]);
        end

        // Master key changes mid-run must not affect the result.
        @(negedge clk);
        master_key = T1_KEY;
        enable     = 1'b1;
        exp_q.push_back(t1_expected());
        repeat (400) @(negedge clk);
        master_key = 256'd0;
        wait_finish("t4", ok);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a run, then a clean re-run.
        master_key = T1_KEY;
        enable     = 1'b1;
        repeat (660) @(negedge clk);
        #2 rst_n = 1'b0;
        enable   = 1'b0;
        #1;
        chk("t5_rst_finish", 128'(finish), 128'd0);
        chk("t5_rst_key1", key_1, 128'd0);
        chk("t5_rst_key3", key_3, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req("t5_rerun", T1_KEY, t1_expected(), 1'b0);

        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
